// File: rtl/led_code_arbiter.sv
// Round-robin sharing of one active-low status LED; each requester
// shows its 1-15 flash blink code followed by a dark gap.
module led_code_arbiter #(
  parameter int TICK_DIV  = 50_000,
  parameter int N_REQ     = 4,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] code,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               done,
  output logic               led
);

  localparam int MAX01 =
    (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAXT =
    (MAX01 > GAP_TICKS) ? MAX01 : GAP_TICKS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = $clog2(MAXT + 1);
  localparam int IW = $clog2(N_REQ);

  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ONL   = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFFL  = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAPL  = TW'(GAP_TICKS - 1);
  localparam logic [IW-1:0] ILAST = IW'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, ON, OFF, GAP
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    presc_q;
  logic [TW-1:0]    timer_q;
  logic [3:0]       cnt_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;
  logic             done_q;
  logic             led_q;
  logic             tick;

  logic             found;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [3:0]       win_code;

  assign tick  = (presc_q == PLAST);
  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign led   = led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_oh   = '0;
    win_code = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (IW'(j) >= ptr_q)) begin
        found     = 1'b1;
        win_idx   = IW'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_code  = code[4*j +: 4];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j]) begin
        found     = 1'b1;
        win_idx   = IW'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_code  = code[4*j +: 4];
      end
    end
    ptr_d = (win_idx == ILAST) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (tick) begin
        timer_q <= timer_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= LOAD;
            grant_q <= win_oh;
            cnt_q   <= win_code;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            timer_q <= '0;
          end
        end
        LOAD: begin
          timer_q <= '0;
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ON;
            led_q   <= 1'b0;
          end
        end
        ON: begin
          if (tick && timer_q == ONL) begin
            state_q <= OFF;
            cnt_q   <= cnt_q - 1'b1;
            led_q   <= 1'b1;
            timer_q <= '0;
          end
        end
        OFF: begin
          if (tick && timer_q == OFFL) begin
            timer_q <= '0;
            if (cnt_q != 4'd0) begin
              state_q <= ON;
              led_q   <= 1'b0;
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (tick && timer_q == GAPL) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            grant_q <= '0;
            busy_q  <= 1'b0;
            timer_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_code_arbiter.sv
// Bench for led_code_arbiter: scenario tasks plus randomized
// rounds checked against a round-robin / blink-timing model.
module tb_led_code_arbiter;

  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 2;
  localparam int GAPT = 3;
  localparam int ONLO  = (ONT - 1) * TD + 1;
  localparam int ONHI  = ONT * TD;
  localparam int OFFLO = (OFFT - 1) * TD + 1;
  localparam int OFFHI = OFFT * TD;
  localparam int TLLO  = OFFLO + (GAPT - 1) * TD + 1;
  localparam int TLHI  = OFFHI + GAPT * TD;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] code;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic        led;

  int vectors;
  int miscompares;
  int rr_ptr;

  bit          mut_en;
  logic [3:0]  mut_req;
  logic [15:0] mut_code;

  led_code_arbiter #(
    .TICK_DIV (TD),
    .N_REQ    (4),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .code (code),
    .grant(grant),
    .busy (busy),
    .done (done),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Measures one granted sequence from grant to the done cycle.
  task automatic observe_seq(
    output logic [3:0] g, output int nfl, output int badw,
    output int tail, output int gchg, output bit tmo);
    int w, lo_len, hi_len;
    bit prev;
    g = '0; nfl = 0; badw = 0; tail = 0; gchg = 0; tmo = 0;
    w = 0;
    while (grant === 4'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (grant === 4'b0) begin
      tmo = 1;
      mut_en = 0;
      return;
    end
    g = grant;
    prev = 1'b1;
    lo_len = 0;
    hi_len = 0;
    w = 0;
    while (done !== 1'b1 && w < 3000) begin
      if (grant !== g || busy !== 1'b1) gchg++;
      if (mut_en && led === 1'b0) begin
        req = mut_req;
        code = mut_code;
        mut_en = 0;
      end
      if (led === 1'b0) begin
        if (prev) begin
          nfl++;
          if (nfl > 1 && (hi_len < OFFLO || hi_len > OFFHI))
            badw++;
          lo_len = 0;
        end
        lo_len++;
        prev = 1'b0;
      end else begin
        if (!prev) begin
          if (lo_len < ONLO || lo_len > ONHI) badw++;
          hi_len = 0;
        end
        hi_len++;
        prev = 1'b1;
      end
      @(negedge clk);
      w++;
    end
    if (done !== 1'b1) tmo = 1;
    tail = hi_len;
    mut_en = 0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_ptr = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = '0;
    code = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (led !== 1'b1 || grant !== 4'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got led=%b grant=%b busy=%b done=%b expected 1 0000 0 0",
               led, grant, busy, done);
    end
    vectors++;
    if (dut.presc_q !== '0) begin
      miscompares++;
      $display("FAIL reset_presc: got %0d expected 0", dut.presc_q);
    end
    rst_n = 1'b1;
    rr_ptr = 0;
  endtask

  task automatic test_single;
    logic [3:0] g;
    int nfl, badw, tail, gchg, w;
    bit tmo;
    req = 4'b0010;
    code = 16'h0030;
    w = rr_pick(req, rr_ptr);
    observe_seq(g, nfl, badw, tail, gchg, tmo);
    req = '0;
    rr_ptr = (w + 1) % 4;
    vectors++;
    if (tmo) begin
      miscompares++;
      $display("FAIL t1_timeout: got timeout expected done");
    end
    vectors++;
    if (g !== 4'(1 << w)) begin
      miscompares++;
      $display("FAIL t1_grant: got %b expected %b", g, 4'(1 << w));
    end
    vectors++;
    if (nfl != 3 || badw != 0) begin
      miscompares++;
      $display("FAIL t1_flashes: got n=%0d badw=%0d expected 3 0", nfl, badw);
    end
    vectors++;
    if (tail < TLLO || tail > TLHI) begin
      miscompares++;
      $display("FAIL t1_gap: got %0d expected %0d..%0d", tail, TLLO, TLHI);
    end
    vectors++;
    if (gchg != 0 || grant !== 4'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_hold: got gchg=%0d grant=%b busy=%b expected 0 0000 0",
               gchg, grant, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || grant !== 4'b0) begin
      miscompares++;
      $display("FAIL t1_after: got done=%b grant=%b expected 0 0000", done, grant);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] g;
    int nfl, badw, tail, gchg, w;
    bit tmo;
    apply_reset();
    code = 16'h1111;
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      w = rr_pick(req, rr_ptr);
      observe_seq(g, nfl, badw, tail, gchg, tmo);
      rr_ptr = (w + 1) % 4;
      if (r == 4) req = '0;
      vectors++;
      if (tmo || g !== 4'(1 << w)) begin
        miscompares++;
        $display("FAIL t2_grant%0d: got %b tmo=%0d expected %b", r, g, tmo, 4'(1 << w));
      end
      vectors++;
      if (nfl != 1 || badw != 0 || gchg != 0) begin
        miscompares++;
        $display("FAIL t2_seq%0d: got n=%0d badw=%0d gchg=%0d expected 1 0 0",
                 r, nfl, badw, gchg);
      end
      vectors++;
      if (grant !== 4'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL t2_done%0d: got grant=%b busy=%b expected 0000 0", r, grant, busy);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL t2_pulse%0d: got done=%b expected 0", r, done);
      end
    end
  endtask

  task automatic test_zero_code;
    int w;
    logic [3:0] exp;
    code = 16'h1011;
    req = 4'b0100;
    w = rr_pick(req, rr_ptr);
    exp = 4'(1 << w);
    rr_ptr = (w + 1) % 4;
    @(negedge clk);
    req = '0;
    vectors++;
    if (grant !== exp || busy !== 1'b1 ||
        led !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL t3_load: got grant=%b busy=%b led=%b done=%b expected %b 1 1 0",
               grant, busy, led, done, exp);
    end
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0 || busy !== 1'b0 ||
        led !== 1'b1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_done: got grant=%b busy=%b led=%b done=%b expected 0000 0 1 1",
               grant, busy, led, done);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || led !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_after: got done=%b led=%b expected 0 1", done, led);
    end
  endtask

  task automatic test_no_preempt;
    logic [3:0] g;
    int nfl, badw, tail, gchg, w;
    bit tmo;
    code = 16'h1002;
    req = 4'b0001;
    mut_req = 4'b1000;
    mut_code = 16'h1009;
    mut_en = 1;
    w = rr_pick(req, rr_ptr);
    observe_seq(g, nfl, badw, tail, gchg, tmo);
    rr_ptr = (w + 1) % 4;
    vectors++;
    if (tmo || g !== 4'(1 << w) || gchg != 0) begin
      miscompares++;
      $display("FAIL t4_first: got grant=%b tmo=%0d gchg=%0d expected %b 0 0",
               g, tmo, gchg, 4'(1 << w));
    end
    vectors++;
    if (nfl != 2 || badw != 0) begin
      miscompares++;
      $display("FAIL t4_flashes: got n=%0d badw=%0d expected 2 0", nfl, badw);
    end
    w = rr_pick(req, rr_ptr);
    observe_seq(g, nfl, badw, tail, gchg, tmo);
    req = '0;
    rr_ptr = (w + 1) % 4;
    vectors++;
    if (tmo || g !== 4'(1 << w) || nfl != 1 || gchg != 0) begin
      miscompares++;
      $display("FAIL t4_second: got grant=%b n=%0d tmo=%0d expected %b 1 0",
               g, nfl, tmo, 4'(1 << w));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [3:0] g;
    int nfl, badw, tail, gchg, w;
    bit tmo;
    code = 16'h0005;
    req = 4'b0001;
    w = 0;
    while (led !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    while (led !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (w >= 200) begin
      miscompares++;
      $display("FAIL t5_reach_off: got timeout expected first OFF");
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (led !== 1'b1 || grant !== 4'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_async: got led=%b grant=%b busy=%b expected 1 0000 0",
               led, grant, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_ptr = 0;
    w = rr_pick(req, rr_ptr);
    observe_seq(g, nfl, badw, tail, gchg, tmo);
    req = '0;
    rr_ptr = (w + 1) % 4;
    vectors++;
    if (tmo || g !== 4'(1 << w) || gchg != 0) begin
      miscompares++;
      $display("FAIL t5_regrant: got grant=%b tmo=%0d gchg=%0d expected %b 0 0",
               g, tmo, gchg, 4'(1 << w));
    end
    vectors++;
    if (nfl != 5 || badw != 0 || tail < TLLO || tail > TLHI) begin
      miscompares++;
      $display("FAIL t5_replay: got n=%0d badw=%0d tail=%0d expected 5 0 %0d..%0d",
               nfl, badw, tail, TLLO, TLHI);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [3:0] g, ef;
    int nfl, badw, tail, gchg, w;
    bit tmo;
    for (int r = 0; r < 12; r++) begin
      req = 4'($urandom_range(15, 1));
      for (int k = 0; k < 4; k++)
        code[4*k +: 4] = 4'($urandom_range(3, 0));
      mut_req = 4'($urandom_range(15, 0));
      mut_code = 16'($urandom);
      mut_en = 1;
      w = rr_pick(req, rr_ptr);
      ef = code[4*w +: 4];
      observe_seq(g, nfl, badw, tail, gchg, tmo);
      rr_ptr = (w + 1) % 4;
      vectors++;
      if (tmo || g !== 4'(1 << w) || gchg != 0) begin
        miscompares++;
        $display("FAIL rnd%0d_grant: got %b tmo=%0d gchg=%0d expected %b",
                 r, g, tmo, gchg, 4'(1 << w));
      end
      vectors++;
      if (nfl != int'(ef) || badw != 0) begin
        miscompares++;
        $display("FAIL rnd%0d_flashes: got n=%0d badw=%0d expected %0d 0",
                 r, nfl, badw, ef);
      end
      vectors++;
      if ((ef == 0 && tail != 1) ||
          (ef != 0 && (tail < TLLO || tail > TLHI))) begin
        miscompares++;
        $display("FAIL rnd%0d_tail: got %0d expected code=%0d", r, tail, ef);
      end
      vectors++;
      if (grant !== 4'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd%0d_done: got grant=%b busy=%b expected 0000 0",
                 r, grant, busy);
      end
    end
    req = '0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL rnd_end: got done=%b expected 0", done);
    end
  endtask

  task automatic test_idle;
    int bad, badtick, nt, last;
    bad = 0;
    badtick = 0;
    nt = 0;
    last = -1;
    req = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (led !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      if (dut.tick === 1'b1) begin
        if (last >= 0 && i - last != TD) badtick++;
        last = i;
        nt++;
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL t6_idle: got %0d bad cycles expected 0", bad);
    end
    vectors++;
    if (badtick != 0 || nt < 1000 / TD - 1) begin
      miscompares++;
      $display("FAIL t6_tick: got badint=%0d ticks=%0d expected 0 >=%0d",
               badtick, nt, 1000 / TD - 1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mut_en = 0;
    mut_req = '0;
    mut_code = '0;
    rst_n = 1'b0;
    req = '0;
    code = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_code();
    test_no_preempt();
    test_reset_mid();
    test_random();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
